// File: rtl/dcache_refill_ctrl.sv
// Data-cache refill controller: optional dirty-line writeback, then a line read and a fill
// back to the cache. At most one memory transaction is in flight; protocol faults and timeouts raise a sticky error.
package dcache_refill_pkg;
  typedef logic [31:0] bus32_t;
  localparam int unsigned LINE_W = 128;
endpackage

module dcache_refill_ctrl
  import dcache_refill_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              miss_valid_i,
  output logic              miss_ready_o,
  input  bus32_t            miss_addr_i,
  input  logic              evict_valid_i,
  input  bus32_t            evict_addr_i,
  input  logic [LINE_W-1:0] evict_data_i,
  output logic              fill_valid_o,
  input  logic              fill_ready_i,
  output bus32_t            fill_addr_o,
  output logic [LINE_W-1:0] fill_data_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output bus32_t            mem_addr_o,
  output logic              mem_we_o,
  output logic [LINE_W-1:0] mem_data_wr_o,
  input  logic              mem_rsp_valid_i,
  output logic              mem_rsp_ready_o,
  input  bus32_t            mem_rsp_addr_i,
  input  logic [LINE_W-1:0] mem_data_line_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned CNT_W      = $clog2(TIMEOUT + 1);
  localparam bus32_t      ALIGN_MASK = 32'hFFFF_FFF0;

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_RSP, RD_REQ, RD_RSP, FILL} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_d, post_rst_q;
  bus32_t            miss_addr_q, miss_addr_d, evict_addr_q, evict_addr_d;
  logic [LINE_W-1:0] evict_data_q, evict_data_d, fill_data_d;
  logic              rsp_state, rsp_match;
  logic              busy_d, miss_ready_d, req_valid_d, we_d, rsp_ready_d, fill_valid_d;
  bus32_t            mem_addr_d, fill_addr_d;
  logic [LINE_W-1:0] mem_data_d;

  // Next state, captured line info and the next value of every registered output
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_o;
    miss_addr_d  = miss_addr_q;
    evict_addr_d = evict_addr_q;
    evict_data_d = evict_data_q;
    fill_data_d  = fill_data_o;
    rsp_state    = (state_q == WB_RSP) || (state_q == RD_RSP);
    rsp_match    = mem_rsp_valid_i &&
                   (mem_rsp_addr_i == ((state_q == WB_RSP) ? evict_addr_q : miss_addr_q));

    case (state_q)
      IDLE: begin
        if (miss_valid_i && miss_ready_o) begin
          miss_addr_d  = miss_addr_i & ALIGN_MASK;
          evict_addr_d = evict_addr_i & ALIGN_MASK;
          evict_data_d = evict_data_i;
          state_d      = evict_valid_i ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        if (mem_req_ready_i) begin
          state_d = WB_RSP;
          cnt_d   = '0;
        end
      end
      RD_REQ: begin
        if (mem_req_ready_i) begin
          state_d = RD_RSP;
          cnt_d   = '0;
        end
      end
      WB_RSP, RD_RSP: begin
        if (rsp_match) begin
          if (state_q == RD_RSP) begin
            fill_data_d = mem_data_line_i;
            state_d     = FILL;
          end else begin
            state_d = RD_REQ;
          end
        end else begin
          // A stray address is dropped but still counts as a protocol fault
          if (mem_rsp_valid_i) err_d = 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FILL: begin
        if (fill_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Unsolicited responses fault, except a leftover one right after reset
    if (mem_rsp_valid_i && !rsp_state && !post_rst_q) err_d = 1'b1;

    busy_d       = (state_d != IDLE);
    miss_ready_d = (state_d == IDLE) && !err_d;
    req_valid_d  = (state_d == WB_REQ) || (state_d == RD_REQ);
    we_d         = (state_d == WB_REQ);
    mem_addr_d   = '0;
    mem_data_d   = '0;
    if (state_d == WB_REQ) begin
      mem_addr_d = evict_addr_d;
      mem_data_d = evict_data_d;
    end else if (state_d == RD_REQ) begin
      mem_addr_d = miss_addr_d;
    end
    rsp_ready_d  = (state_d == WB_RSP) || (state_d == RD_RSP);
    fill_valid_d = (state_d == FILL);
    fill_addr_d  = (state_d == FILL) ? miss_addr_d : '0;
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      err_o           <= 1'b0;
      post_rst_q      <= 1'b1;
      miss_addr_q     <= '0;
      evict_addr_q    <= '0;
      evict_data_q    <= '0;
      fill_data_o     <= '0;
      busy_o          <= 1'b0;
      miss_ready_o    <= 1'b1;
      mem_req_valid_o <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_addr_o      <= '0;
      mem_data_wr_o   <= '0;
      mem_rsp_ready_o <= 1'b0;
      fill_valid_o    <= 1'b0;
      fill_addr_o     <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      err_o           <= err_d;
      post_rst_q      <= 1'b0;
      miss_addr_q     <= miss_addr_d;
      evict_addr_q    <= evict_addr_d;
      evict_data_q    <= evict_data_d;
      fill_data_o     <= fill_data_d;
      busy_o          <= busy_d;
      miss_ready_o    <= miss_ready_d;
      mem_req_valid_o <= req_valid_d;
      mem_we_o        <= we_d;
      mem_addr_o      <= mem_addr_d;
      mem_data_wr_o   <= mem_data_d;
      mem_rsp_ready_o <= rsp_ready_d;
      fill_valid_o    <= fill_valid_d;
      fill_addr_o     <= fill_addr_d;
    end
  end

endmodule
